// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle RV32M unit that sits beside the single-cycle ALU in EX. It accepts
// M-type requests (ALUOp=10, Funct7=0000001) and runs a 32-step shift-add
// multiply or restoring divide on operand magnitudes. Signs are applied when
// the result is produced. The pipeline is stalled while the unit is busy.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   Start   in   EX stage holds a valid instruction
//   ALUOp   in   controller ALU op class (M-ops use 2'b10)
//   Funct7  in   instr[31:25]
//   Funct3  in   instr[14:12], MUL..REMU = 000..111
//   SrcA    in   rs1 operand (multiplicand / dividend)
//   SrcB    in   rs2 operand (multiplier / divisor)
//   Flush   in   kill the in-flight operation
//   Stall   out  hold IF/ID/EX registers (combinational)
//   Done    out  one-cycle pulse, Result valid
//   Result  out  M-op result, held until the next completion
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Start,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            Flush,
    output logic            Stall,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    localparam int unsigned AW = 2 * XLEN;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [AW-1:0]    acc_q, acc_d;     // {hi, lo} product or {remainder, quotient}
    logic             neg_q, neg_d;     // negate the selected result word
    logic             done_q, done_d;
    logic [XLEN-1:0]  result_q, result_d;

    // Request decode and operand sign handling
    logic            req;
    logic            a_neg, b_neg, neg_sel;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;

    assign req = Start && (ALUOp == 2'b10) && (Funct7 == 7'b0000001);

    assign a_neg = SrcA[XLEN-1] &&
                   ((Funct3 == OP_MULH) || (Funct3 == OP_MULHSU) ||
                    (Funct3 == OP_DIV)  || (Funct3 == OP_REM));
    assign b_neg = SrcB[XLEN-1] &&
                   ((Funct3 == OP_MULH) || (Funct3 == OP_DIV) || (Funct3 == OP_REM));
    assign a_mag = a_neg ? (~SrcA + XLEN'(1)) : SrcA;
    assign b_mag = b_neg ? (~SrcB + XLEN'(1)) : SrcB;

    // Remainder follows the dividend; every other signed op uses the sign XOR
    assign neg_sel = (Funct3 == OP_REM) ? a_neg :
                     ((Funct3 == OP_MULH) || (Funct3 == OP_MULHSU) ||
                      (Funct3 == OP_DIV)) ? (a_neg ^ b_neg) : 1'b0;

    assign div_zero = Funct3[2] && (SrcB == '0);
    assign div_ovf  = ((Funct3 == OP_DIV) || (Funct3 == OP_REM)) &&
                      (SrcA == MIN_NEG) && (SrcB == ALL_ONES);

    // One multiply step: conditional add into the high half, then shift right
    logic [XLEN:0]   mul_sum;
    logic [AW-1:0]   mul_next;
    assign mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // One restoring-divide step: the shifted remainder is XLEN+1 bits wide so
    // the top bit of the subtraction is the borrow
    logic [XLEN:0]   div_diff;
    logic [AW-1:0]   div_next;
    assign div_diff = acc_q[AW-1:XLEN-1] - {1'b0, opnd_q};
    assign div_next = div_diff[XLEN] ? {acc_q[AW-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    // Final word selection with sign correction
    function automatic logic [XLEN-1:0] fin_result(input logic [2:0]    op,
                                                   input logic          neg,
                                                   input logic [AW-1:0] acc);
        logic [AW-1:0]   prod_n;
        logic [XLEN-1:0] quo, rem;
        prod_n = ~acc + AW'(1);
        quo    = acc[XLEN-1:0];
        rem    = acc[AW-1:XLEN];
        case (op)
            OP_MUL:                       fin_result = quo;
            OP_MULH, OP_MULHSU, OP_MULHU: fin_result = neg ? prod_n[AW-1:XLEN] : rem;
            OP_DIV, OP_DIVU:              fin_result = neg ? (~quo + XLEN'(1)) : quo;
            default:                      fin_result = neg ? (~rem + XLEN'(1)) : rem;
        endcase
    endfunction

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req && !Flush) begin
                    op_d  = Funct3;
                    cnt_d = '0;
                    if (div_zero) begin
                        // Quotient all ones, remainder is the raw dividend
                        acc_d   = {SrcA, ALL_ONES};
                        neg_d   = 1'b0;
                        state_d = S_FIN;
                    end else if (div_ovf) begin
                        acc_d   = {{XLEN{1'b0}}, MIN_NEG};
                        neg_d   = 1'b0;
                        state_d = S_FIN;
                    end else begin
                        neg_d   = neg_sel;
                        state_d = S_CALC;
                        if (Funct3[2]) begin
                            acc_d  = {{XLEN{1'b0}}, a_mag};
                            opnd_d = b_mag;
                        end else begin
                            acc_d  = {{XLEN{1'b0}}, b_mag};
                            opnd_d = a_mag;
                        end
                    end
                end
            end
            S_CALC: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Result and Done are captured on entry to FIN
        if (state_d == S_FIN) begin
            done_d   = 1'b1;
            result_d = fin_result(op_d, neg_d, acc_d);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign Stall  = ((state_q == S_IDLE) && req && !Flush) || (state_q == S_CALC);
    assign Done   = done_q;
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed self-checking bench: expected results are queued when an op is
// driven and popped when Done is seen. Inputs change on the falling edge,
// outputs are sampled on the falling edge (Stall #1 after inputs settle).
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [1:0]  ALUOp;
    logic [6:0]  Funct7;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Flush;
    logic        Stall;
    logic        Done;
    logic [31:0] Result;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb[$];
    logic [31:0] last_res;

    muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .ALUOp  (ALUOp),
        .Funct7 (Funct7),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Flush  (Flush),
        .Stall  (Stall),
        .Done   (Done),
        .Result (Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        Start  = 1'b1;
        ALUOp  = 2'b10;
        Funct7 = 7'b0000001;
        Funct3 = f3;
        SrcA   = a;
        SrcB   = b;
        Flush  = 1'b0;
    endtask

    // Issue one M-op, wait (bounded) for Done, compare latency, Stall and Result
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        logic        got;
        logic [31:0] e;
        @(negedge clk);
        drive_m(f3, a, b);
        sb.push_back(exp);
        #1 check({tag, "_stall_T"}, 64'(Stall), 64'(1));
        got = 1'b0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (Done) begin
                got = 1'b1;
                check({tag, "_latency"}, 64'(n), 64'(lat));
                check({tag, "_stall_fin"}, 64'(Stall), 64'(0));
                e = sb.pop_front();
                check({tag, "_result"}, 64'(Result), 64'(e));
                last_res = e;
                Start = 1'b0;
            end else begin
                check({tag, "_stall_busy"}, 64'(Stall), 64'(1));
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $error("FAIL %s_timeout observed=no_done expected=done", tag);
            void'(sb.pop_front());
        end else begin
            @(negedge clk);
            check({tag, "_done_low"}, 64'(Done), 64'(0));
            check({tag, "_hold"}, 64'(Result), 64'(last_res));
        end
    endtask

    initial begin
        reset  = 1'b1;
        Start  = 1'b0;
        ALUOp  = 2'b00;
        Funct7 = 7'b0;
        Funct3 = 3'b0;
        SrcA   = 32'h0;
        SrcB   = 32'h0;
        Flush  = 1'b0;
        last_res = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 64'(Stall), 64'(0));
        check("rst_done", 64'(Done), 64'(0));
        check("rst_result", 64'(Result), 64'(0));
        reset = 1'b0;

        // Multiply family
        do_op("mul_7x6",       3'b000, 32'd7,        32'd6,        32'd42,       33);
        do_op("mulhu_max",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        do_op("mulh_m1x2",     3'b001, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        do_op("mulhsu_m1x2",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        do_op("mul_wrap",      3'b000, 32'h80000000, 32'd2,        32'h00000000, 33);
        do_op("mulh_neg_neg",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);

        // Divide family
        do_op("div_m7_2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        do_op("rem_m7_2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        do_op("divu_100_7",    3'b101, 32'd100,      32'd7,        32'd14,       33);
        do_op("remu_100_7",    3'b111, 32'd100,      32'd7,        32'd2,        33);
        do_op("divu_big",      3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33);

        // Fast paths
        do_op("divu_5_0",      3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        do_op("rem_5_0",       3'b110, 32'd5,        32'd0,        32'd5,        1);
        do_op("rem_m7_0",      3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);
        do_op("div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_op("rem_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        do_op("divu_1000_3",   3'b101, 32'd1000,     32'd3,        32'd333,      33);

        // Flush during CALC: DIV 1000/3, Flush at T+10
        @(negedge clk);
        drive_m(3'b100, 32'd1000, 32'd3);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 10) Flush = 1'b1;
            #1 check("flush_busy_stall", 64'(Stall), 64'(1));
            check("flush_busy_done", 64'(Done), 64'(0));
        end
        @(negedge clk);
        #1 check("flush_idle_stall", 64'(Stall), 64'(0));
        check("flush_no_done", 64'(Done), 64'(0));
        check("flush_result_kept", 64'(Result), 64'(last_res));
        do_op("mul_after_flush", 3'b000, 32'd3, 32'd3, 32'd9, 33);

        // Reset in the middle of a MUL
        @(negedge clk);
        drive_m(3'b000, 32'd5, 32'd5);
        for (int n = 1; n <= 5; n++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        Start = 1'b0;
        #1 check("midrst_stall", 64'(Stall), 64'(0));
        check("midrst_done", 64'(Done), 64'(0));
        check("midrst_result", 64'(Result), 64'(0));

        // Non-M requests: ADD (Funct7=0) and wrong ALUOp are ignored
        @(negedge clk);
        Start  = 1'b1;
        ALUOp  = 2'b10;
        Funct7 = 7'b0000000;
        Funct3 = 3'b000;
        SrcA   = 32'd7;
        SrcB   = 32'd6;
        for (int n = 0; n < 40; n++) begin
            if (n == 20) begin
                ALUOp  = 2'b00;
                Funct7 = 7'b0000001;
            end
            #1 check("nonm_stall", 64'(Stall), 64'(0));
            check("nonm_done", 64'(Done), 64'(0));
            @(negedge clk);
        end
        Start = 1'b0;
        check("nonm_result", 64'(Result), 64'(0));

        // A valid op still works afterwards
        do_op("mulhu_small", 3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 33);

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
